mem_responder: RTL and testbench

Unified instruction/data memory that answers the CPU core's fetch port (`iaddr`/`idata`) and load/store port (`addr`/`wdata`/`wr`/`data`). It also contains a byte-stream boot loader that fills memory while holding the core in reset, then releases it. It sits beside `cpu` at the top level, and its `core_rst_n` output drives the core's `rst_n`.

---
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - unified instruction/data memory with byte-stream boot loader
// Holds the core in reset while LOAD streams bytes into memory, then serves fetch/load/store in RUN.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter bit BOOT_LOAD   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iaddr,
  output logic [31:0] idata,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr,
  output logic [31:0] data,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        core_rst_n,
  output logic        ovf,
  output logic        err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH32  = 32'(DEPTH_WORDS);
  localparam logic [AW:0] PTR_FULL = (AW + 1)'(DEPTH_WORDS);

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [AW:0] r_word_ptr;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_asm;
  logic [31:0] r_idata;
  logic [31:0] r_data;
  logic        r_core_rst_n;
  logic        r_ovf;
  logic        r_err;

  logic        w_run;
  logic        w_ld_take;
  logic        w_ld_due;
  logic        w_ptr_full;
  logic        w_i_oor;
  logic        w_d_oor;
  logic [31:0] w_ld_word;
  logic        w_unused;

  assign w_unused   = &{1'b0, iaddr[1:0], addr[1:0]};
  assign w_i_oor    = ({2'b00, iaddr[31:2]} >= DEPTH32);
  assign w_d_oor    = ({2'b00, addr[31:2]} >= DEPTH32);
  assign w_ptr_full = (r_word_ptr == PTR_FULL);

  always_ff @(posedge clk) begin
    if (rst) r_state <= BOOT_LOAD ? S_LOAD : S_RUN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (r_state == S_LOAD && ld_valid && ld_last) w_next = S_RUN;
  end

  always_comb begin
    w_run     = (r_state == S_RUN);
    w_ld_take = !w_run && ld_valid;
    w_ld_due  = w_ld_take && (r_byte_cnt == 2'd3 || ld_last);
  end

  // Bytes not yet received read as zero, which gives the pad-on-ld_last behaviour for free.
  always_comb begin
    w_ld_word = 32'h0;
    case (r_byte_cnt)
      2'd0:    w_ld_word = {24'h0, ld_byte};
      2'd1:    w_ld_word = {16'h0, ld_byte, r_asm[7:0]};
      2'd2:    w_ld_word = {8'h0, ld_byte, r_asm[15:0]};
      default: w_ld_word = {ld_byte, r_asm};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_ptr   <= '0;
      r_byte_cnt   <= 2'd0;
      r_asm        <= 24'h0;
      r_idata      <= 32'h0;
      r_data       <= 32'h0;
      r_core_rst_n <= 1'b0;
      r_ovf        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_core_rst_n <= w_run;
      if (w_ld_take) begin
        r_byte_cnt <= ld_last ? 2'd0 : r_byte_cnt + 2'd1;
        if (r_byte_cnt != 2'd3) r_asm <= w_ld_word[23:0];
      end
      if (w_ld_due) begin
        if (w_ptr_full) r_ovf      <= 1'b1;
        else            r_word_ptr <= r_word_ptr + (AW + 1)'(1);
      end
      if (w_run) begin
        r_idata <= w_i_oor ? 32'h0 : r_mem[iaddr[AW+1:2]];
        r_data  <= w_d_oor ? 32'h0 : r_mem[addr[AW+1:2]];
        // Data-port reads alone never flag: addr carries stale values between accesses.
        if (w_i_oor || (wr && w_d_oor)) r_err <= 1'b1;
      end else begin
        r_idata <= 32'h0;
        r_data  <= 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_run && wr && !w_d_oor)
        r_mem[addr[AW+1:2]] <= wdata;
      else if (w_ld_due && !w_ptr_full)
        r_mem[r_word_ptr[AW-1:0]] <= w_ld_word;
    end
  end

  assign idata      = r_idata;
  assign data       = r_data;
  assign core_rst_n = r_core_rst_n;
  assign ovf        = r_ovf;
  assign err        = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
// Three instances share all inputs: default (1024 words), tiny (4 words), and no-boot-load.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] iaddr = 32'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        wr = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h0;
  logic        ld_last = 1'b0;

  logic [31:0] idata_a, data_a, idata_s, data_s, idata_n, data_n;
  logic        crn_a, ovf_a, err_a, crn_s, ovf_s, err_s, crn_n, ovf_n, err_n;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .BOOT_LOAD(1'b1)) dut_a (
    .clk(clk), .rst(rst), .iaddr(iaddr), .idata(idata_a), .addr(addr), .wdata(wdata), .wr(wr),
    .data(data_a), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .core_rst_n(crn_a), .ovf(ovf_a), .err(err_a));

  mem_responder #(.DEPTH_WORDS(4), .BOOT_LOAD(1'b1)) dut_s (
    .clk(clk), .rst(rst), .iaddr(iaddr), .idata(idata_s), .addr(addr), .wdata(wdata), .wr(wr),
    .data(data_s), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .core_rst_n(crn_s), .ovf(ovf_s), .err(err_s));

  mem_responder #(.DEPTH_WORDS(16), .BOOT_LOAD(1'b0)) dut_n (
    .clk(clk), .rst(rst), .iaddr(iaddr), .idata(idata_n), .addr(addr), .wdata(wdata), .wr(wr),
    .data(data_n), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .core_rst_n(crn_n), .ovf(ovf_n), .err(err_n));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (idata_a !== 32'h0) begin bad++; $display("FAIL reset_idata got=%h exp=0", idata_a); end
    total++; if (data_a !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_a); end
    total++; if (crn_a !== 1'b0) begin bad++; $display("FAIL reset_core_rst_n got=%b exp=0", crn_a); end
    total++; if (ovf_a !== 1'b0 || err_a !== 1'b0) begin bad++; $display("FAIL reset_flags got ovf=%b err=%b exp 0 0", ovf_a, err_a); end
    total++; if (crn_n !== 1'b0) begin bad++; $display("FAIL noboot_reset_crn got=%b exp=0", crn_n); end
    rst = 1'b0;
    tick();
    total++; if (crn_n !== 1'b1) begin bad++; $display("FAIL noboot_release got=%b exp=1", crn_n); end
    total++; if (crn_a !== 1'b0) begin bad++; $display("FAIL boot_held got=%b exp=0", crn_a); end
  endtask

  task automatic test_interrupted_load();
    int low_errs = 0;
    for (int i = 0; i < 6; i++) begin
      send_byte(8'h50 + 8'(i), 1'b0);
      if (crn_a !== 1'b0) low_errs++;
    end
    do_reset();
    if (crn_a !== 1'b0) low_errs++;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(i + 1), i == 3);
      if (crn_a !== 1'b0) low_errs++;
    end
    total++; if (low_errs != 0) begin bad++; $display("FAIL intr_crn_low got=%0d highs exp=0", low_errs); end
    addr = 32'h0;
    tick();
    total++; if (data_a !== 32'h04030201) begin bad++; $display("FAIL intr_mem0 got=%h exp=04030201", data_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL intr_ovf got=%b exp=0", ovf_a); end
  endtask

  task automatic test_boot_load();
    logic [7:0] bytes [8];
    bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    do_reset();
    iaddr = 32'h0;
    addr  = 32'h4;
    for (int i = 0; i < 8; i++) send_byte(bytes[i], i == 7);
    total++; if (crn_a !== 1'b0) begin bad++; $display("FAIL boot_crn_at_last got=%b exp=0", crn_a); end
    tick();
    total++; if (crn_a !== 1'b1) begin bad++; $display("FAIL boot_crn_rise got=%b exp=1", crn_a); end
    total++; if (idata_a !== 32'h00000013) begin bad++; $display("FAIL boot_idata got=%h exp=00000013", idata_a); end
    total++; if (data_a !== 32'h00500093) begin bad++; $display("FAIL boot_mem1 got=%h exp=00500093", data_a); end
  endtask

  task automatic test_store();
    addr = 32'h40; wdata = 32'h11111111; wr = 1'b1;
    tick();
    wdata = 32'hDEADBEEF; iaddr = 32'h40;
    tick();
    wr = 1'b0;
    total++; if (data_a !== 32'h11111111) begin bad++; $display("FAIL rbw_data got=%h exp=11111111", data_a); end
    total++; if (idata_a !== 32'h11111111) begin bad++; $display("FAIL rbw_idata got=%h exp=11111111", idata_a); end
    tick();
    total++; if (data_a !== 32'hDEADBEEF) begin bad++; $display("FAIL store_data got=%h exp=deadbeef", data_a); end
    total++; if (idata_a !== 32'hDEADBEEF) begin bad++; $display("FAIL store_idata got=%h exp=deadbeef", idata_a); end
    iaddr = 32'h0;
  endtask

  task automatic test_out_of_range();
    addr = 32'h2000;
    tick();
    total++; if (data_a !== 32'h0) begin bad++; $display("FAIL oor_data got=%h exp=0", data_a); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL oor_dread_err got=%b exp=0", err_a); end
    iaddr = 32'h1000;
    tick();
    total++; if (idata_a !== 32'h0) begin bad++; $display("FAIL oor_idata got=%h exp=0", idata_a); end
    total++; if (err_a !== 1'b1) begin bad++; $display("FAIL oor_err got=%b exp=1", err_a); end
    iaddr = 32'h0; wr = 1'b1; wdata = 32'hBAD0BAD0;
    tick();
    wr = 1'b0; addr = 32'h0;
    tick();
    total++; if (data_a !== 32'h00000013) begin bad++; $display("FAIL oor_write_alias got=%h exp=00000013", data_a); end
  endtask

  task automatic test_partial_load();
    logic [7:0] bytes [5];
    bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_reset();
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL partial_err_clear got=%b exp=0", err_a); end
    for (int i = 0; i < 5; i++) send_byte(bytes[i], i == 4);
    addr = 32'h0;
    tick();
    total++; if (data_a !== 32'hDDCCBBAA) begin bad++; $display("FAIL partial_mem0 got=%h exp=ddccbbaa", data_a); end
    addr = 32'h4;
    tick();
    total++; if (data_a !== 32'h000000EE) begin bad++; $display("FAIL partial_mem1 got=%h exp=000000ee", data_a); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 19; i++) send_byte(8'(i + 1), 1'b0);
    total++; if (ovf_s !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovf_s); end
    send_byte(8'd20, 1'b1);
    total++; if (ovf_s !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf_s); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_big got=%b exp=0", ovf_a); end
    for (int w = 0; w < 4; w++) begin
      addr = 32'(w * 4);
      tick();
      exp = {8'(4 * w + 4), 8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1)};
      total++; if (data_s !== exp) begin bad++; $display("FAIL ovf_word%0d got=%h exp=%h", w, data_s, exp); end
    end
    addr = 32'h10;
    tick();
    total++; if (data_s !== 32'h0) begin bad++; $display("FAIL ovf_beyond got=%h exp=0", data_s); end
  endtask

  initial begin
    test_reset();
    test_interrupted_load();
    test_boot_load();
    test_store();
    test_out_of_range();
    test_partial_load();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
